load_store_unit: RTL and testbench

- Memory-stage block directly downstream of the execute ALU; consumes the ALU result as the effective address.
- Accepts one load/store per request from the pipeline, drives a valid/ready data-memory port and generates byte enables.
- Returns sign- or zero-extended load data to writeback.
- Holds the pipeline stalled while an access is outstanding; misaligned or illegal accesses are flagged without touching memory.

---
 rtl/load_store_unit_if.sv | 22 ++
 rtl/load_store_unit.sv | 89 ++++++++
 tb/tb_load_store_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: data-memory valid/ready request port with in-order read-data return
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    modport master (
        output mem_valid, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_valid, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage issuing one aligned load/store per request and returning extended load data
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] ALUout,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    output logic                  stall,
    load_store_unit_if.master     mem,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            f3_q;
    logic                  we_q;
    logic                  err_q;
    logic [3:0]            be_q, be_nx;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_nx, rdata_q, lane, ld;
    logic                  illegal, misal, accept;
    always_comb begin
        accept   = state == IDLE && req_valid;
        illegal  = MemWrite ? funct3 > 3'b010 : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
        misal    = (funct3[1:0] == 2'b01 && ALUout[0]) || (funct3[1:0] == 2'b10 && ALUout[1:0] != 2'b00);
        be_nx    = funct3[1:0] == 2'b00 ? 4'b0001 << ALUout[1:0] :
                   funct3[1:0] == 2'b01 ? (ALUout[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_nx = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
                   funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
        lane     = mem.mem_rdata >> {addr_q[1:0], 3'b000};
        ld       = f3_q == 3'b000 ? {{24{lane[7]}}, lane[7:0]} :
                   f3_q == 3'b001 ? {{16{lane[15]}}, lane[15:0]} :
                   f3_q == 3'b100 ? {24'b0, lane[7:0]} :
                   f3_q == 3'b101 ? {16'b0, lane[15:0]} : lane;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = req_valid ? ((illegal || misal) ? DONE : REQ) : IDLE;
            REQ:  state_nx = mem.mem_ready ? (we_q ? DONE : WAIT) : REQ;
            WAIT: state_nx = mem.mem_rvalid ? DONE : WAIT;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q  <= ALUout;
                f3_q    <= funct3;
                we_q    <= MemWrite;
                err_q   <= illegal || misal;
                be_q    <= be_nx;
                wdata_q <= wdata_nx;
                rdata_q <= '0;
            end
            if (state == WAIT && mem.mem_rvalid)
                rdata_q <= ld;
        end
    end
    // Request fields come only from registers so they hold steady while mem_ready is low
    assign mem.mem_valid = state == REQ;
    assign mem.mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem.mem_we    = state == REQ && we_q;
    assign mem.mem_be    = state == REQ ? be_q : 4'b0000;
    assign mem.mem_wdata = wdata_q;
    assign req_ready     = state == IDLE;
    assign resp_valid    = state == DONE;
    assign resp_data     = state == DONE ? rdata_q : '0;
    assign resp_err      = state == DONE && err_q;
    assign stall         = state != IDLE && req_valid && !resp_valid;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: cycle-exact directed loads, stores, error cases and mid-access reset
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] ALUout = '0;
    logic [31:0] store_data = '0;
    logic        MemWrite = 1'b0;
    logic [2:0]  funct3 = '0;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    int          n_chk = 0;
    int          n_pass = 0;
    load_store_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) mem ();
    load_store_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .ALUout(ALUout), .store_data(store_data), .MemWrite(MemWrite), .funct3(funct3),
        .stall(stall), .mem(mem), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #2;
    endtask
    // Inputs change 2 time units after the edge; outputs are sampled 1 unit later.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input logic [3:0] be, input logic [31:0] exp);
        req_valid = 1'b1; MemWrite = 1'b0; funct3 = f3; ALUout = a; mem.mem_ready = 1'b1;
        step();
        ALUout = 32'hFFFF_FFFF; funct3 = 3'b111;
        mem.mem_rvalid = 1'b1; mem.mem_rdata = ~rd;
        #1;
        check({tag, "_req_valid"}, mem.mem_valid, 1);
        check({tag, "_addr"}, mem.mem_addr, a & 32'hFFFF_FFFC);
        check({tag, "_be"}, mem.mem_be, be);
        check({tag, "_we"}, mem.mem_we, 0);
        check({tag, "_ready_c1"}, req_ready, 0);
        check({tag, "_stall_c1"}, stall, 1);
        step();
        mem.mem_rdata = rd;
        #1;
        check({tag, "_valid_c2"}, mem.mem_valid, 0);
        check({tag, "_ready_c2"}, req_ready, 0);
        check({tag, "_stall_c2"}, stall, 1);
        step();
        mem.mem_rvalid = 1'b0;
        #1;
        check({tag, "_resp_valid"}, resp_valid, 1);
        check({tag, "_resp_data"}, resp_data, exp);
        check({tag, "_resp_err"}, resp_err, 0);
        check({tag, "_ready_c3"}, req_ready, 0);
        check({tag, "_stall_c3"}, stall, 0);
        req_valid = 1'b0;
        step();
        #1;
        check({tag, "_resp_pulse"}, resp_valid, 0);
        check({tag, "_ready_c4"}, req_ready, 1);
    endtask
    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] be, input logic [31:0] wd,
                            input int nwait);
        req_valid = 1'b1; MemWrite = 1'b1; funct3 = f3; ALUout = a; store_data = d;
        mem.mem_ready = 1'b0;
        step();
        store_data = 32'h5555_5555; ALUout = 32'h0;
        for (int i = 0; i <= nwait; i++) begin
            if (i == nwait) mem.mem_ready = 1'b1;
            #1;
            check({tag, "_valid"}, mem.mem_valid, 1);
            check({tag, "_addr"}, mem.mem_addr, a & 32'hFFFF_FFFC);
            check({tag, "_we"}, mem.mem_we, 1);
            check({tag, "_be"}, mem.mem_be, be);
            check({tag, "_wdata"}, mem.mem_wdata, wd);
            check({tag, "_stall"}, stall, 1);
            check({tag, "_resp_early"}, resp_valid, 0);
            step();
        end
        mem.mem_ready = 1'b0;
        #1;
        check({tag, "_resp_valid"}, resp_valid, 1);
        check({tag, "_resp_data"}, resp_data, 0);
        check({tag, "_resp_err"}, resp_err, 0);
        check({tag, "_valid_done"}, mem.mem_valid, 0);
        req_valid = 1'b0;
        step();
        #1;
        check({tag, "_ready_after"}, req_ready, 1);
        check({tag, "_resp_pulse"}, resp_valid, 0);
    endtask
    task automatic do_err(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a);
        req_valid = 1'b1; MemWrite = we; funct3 = f3; ALUout = a; store_data = 32'hFFFF_FFFF;
        mem.mem_ready = 1'b1;
        step();
        #1;
        check({tag, "_resp_valid"}, resp_valid, 1);
        check({tag, "_resp_err"}, resp_err, 1);
        check({tag, "_resp_data"}, resp_data, 0);
        check({tag, "_mem_valid"}, mem.mem_valid, 0);
        req_valid = 1'b0;
        step();
        #1;
        check({tag, "_mem_valid_after"}, mem.mem_valid, 0);
        check({tag, "_ready_after"}, req_ready, 1);
        check({tag, "_resp_pulse"}, resp_valid, 0);
    endtask
    initial begin
        mem.mem_ready = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;
        #13;
        check("rst_req_ready", req_ready, 1);
        check("rst_mem_valid", mem.mem_valid, 0);
        check("rst_mem_we", mem.mem_we, 0);
        check("rst_mem_be", mem.mem_be, 0);
        check("rst_mem_addr", mem.mem_addr, 0);
        check("rst_mem_wdata", mem.mem_wdata, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_stall", stall, 0);
        step();
        rst = 1'b1;
        step();
        do_load("lw", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        do_load("lb", 3'b000, 32'h0000_0103, 32'h8011_2233, 4'b1000, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h0000_0103, 32'h8011_2233, 4'b1000, 32'h0000_0080);
        do_load("lb1", 3'b000, 32'h0000_0101, 32'h0000_7F00, 4'b0010, 32'h0000_007F);
        do_load("lh", 3'b001, 32'h0000_0102, 32'h8001_7FFF, 4'b1100, 32'hFFFF_8001);
        do_load("lhu", 3'b101, 32'h0000_0102, 32'h8001_7FFF, 4'b1100, 32'h0000_8001);
        do_load("lh0", 3'b001, 32'h0000_0100, 32'h1234_8765, 4'b0011, 32'hFFFF_8765);
        do_store("sh", 3'b001, 32'h0000_0202, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD, 0);
        do_store("sb", 3'b000, 32'h0000_0201, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5, 0);
        do_store("sw_wait", 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 5);
        do_err("lw_mis", 1'b0, 3'b010, 32'h0000_0101);
        do_err("st_f3_100", 1'b1, 3'b100, 32'h0000_0200);
        do_err("ld_f3_011", 1'b0, 3'b011, 32'h0000_0000);
        do_err("ld_f3_110", 1'b0, 3'b110, 32'h0000_0000);
        do_err("lh_mis", 1'b0, 3'b001, 32'h0000_0101);
        do_err("lhu_mis", 1'b0, 3'b101, 32'h0000_0103);
        do_err("sh_mis", 1'b1, 3'b001, 32'h0000_0203);
        // Reset while a load waits in WAIT, then a stale rvalid after release
        req_valid = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUout = 32'h0000_0300;
        mem.mem_ready = 1'b1;
        step();
        step();
        rst = 1'b0; req_valid = 1'b0;
        #1;
        check("mid_rst_mem_valid", mem.mem_valid, 0);
        check("mid_rst_req_ready", req_ready, 1);
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_stall", stall, 0);
        step();
        rst = 1'b1;
        step();
        mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            check("post_rst_resp_valid", resp_valid, 0);
            check("post_rst_req_ready", req_ready, 1);
            check("post_rst_mem_valid", mem.mem_valid, 0);
        end
        mem.mem_rvalid = 1'b0;
        step();
        do_load("lw_after_rst", 3'b010, 32'h0000_0304, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
